div_stream_ctrl: RTL and testbench
==================================

// Module: div_stream_ctrl
// PURPOSE
//  Stream front-end/back-end for the sequential radix-2 divider. Buffers divide
//  requests in a small FIFO and issues them one at a time over the divider's
//  start/ready/done handshake. Captures quotient and remainder on done and
//  presents them on a valid/ready result port, tagged with the request tag.
//  Handles divide-by-zero locally, without issuing it to the divider.
// PARAMETERS
//  W      8  operand/result width (must match the divider's W)
//  DEPTH  4  request FIFO depth (power of 2, >=2)
//  TAG_W  4  request tag width
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid&in_ready; equals !fifo_full
//  in_dvnd    in   W      dividend
//  in_dvsr    in   W      divisor
//  in_tag     in   TAG_W  request tag, returned with the result
//  div_start  out  1      one-cycle start pulse to the divider
//  div_dvnd   out  W      dividend to the divider; valid while div_start=1
//  div_dvsr   out  W      divisor to the divider; valid while div_start=1
//  div_ready  in   1      divider idle
//  div_done   in   1      divider done pulse; div_quo/div_rmd valid in this cycle
//  div_quo    in   W      divider quotient
//  div_rmd    in   W      divider remainder
//  out_valid  out  1      result valid
//  out_ready  in   1      result consumer ready
//  out_quo    out  W      quotient
//  out_rmd    out  W      remainder
//  out_tag    out  TAG_W  tag of the result
//  out_dbz    out  1      result came from a divide-by-zero request
//  err        out  1      sticky error: div_done seen outside the WAIT state
// BEHAVIOUR
//  - Reset: FIFO empty, FSM=IDLE, err=0.
//    Reset values: in_ready=1; div_start, out_valid, out_dbz = 0;
//    out_quo, out_rmd, out_tag, div_dvnd, div_dvsr = 0.
//  - FIFO: registered, DEPTH entries of {tag,dvsr,dvnd}; wrap-around pointers plus count.
//    Push on in_valid&in_ready; pop under FSM control.
//    When full, in_ready=0 and no push occurs, even if a pop happens the same cycle.
//    Push and pop in the same cycle on a non-full FIFO leaves the count unchanged.
//    A pushed entry is visible at the FIFO head the cycle after the push.
//  - FSM states: IDLE, WAIT, HOLD.
//    IDLE, FIFO non-empty, head dvsr==0:
//      pop; load out_quo={W{1'b1}}, out_rmd=head dvnd, out_tag, out_dbz=1; ->HOLD.
//    IDLE, FIFO non-empty, head dvsr!=0, div_ready=1:
//      div_start=1 (combinational, this cycle only);
//      div_dvnd/div_dvsr = head fields; latch head tag; pop; ->WAIT.
//    IDLE, div_ready=0: stall; no start is issued.
//    WAIT: on div_done, register div_quo/div_rmd/latched tag into the output regs,
//      out_dbz=0; ->HOLD. No timeout; divider latency is arbitrary.
//    HOLD: out_valid=1; outputs stay stable until out_ready=1.
//      On the handshake ->IDLE; the next issue occurs the following cycle,
//      so there is no issue on the handshake cycle.
//  - Latency (empty FIFO, divider idle):
//    accept at cycle 0 -> div_start at cycle 1.
//    Divide-by-zero request -> out_valid at cycle 2.
//    Normal request -> out_valid the cycle after div_done.
//  - Only one request is in flight. Results are returned in request order.
//  - div_done in IDLE or HOLD is ignored for data and sets err (cleared only by rst).
//  - Reset mid-operation: the FIFO and any in-flight result are discarded.
//    The divider shares rst, so no stale done is expected afterwards.
//  - Widths: all arithmetic is W-bit unsigned; the FIFO count is clog2(DEPTH)+1 bits.
// TESTING
//  1. Reset, then dvnd=100, dvsr=7, tag=3 -> div_start 1 cycle after accept;
//     out: quo=14, rmd=2, tag=3, dbz=0.
//  2. dvnd=55, dvsr=0, tag=9 -> div_start never pulses; out_valid at cycle 2;
//     out: quo=8'hFF, rmd=55, dbz=1.
//  3. Hold out_ready=0 and push 5 requests -> in_ready drops after the FIFO fills
//     (4 queued plus 1 in flight). Release -> results arrive in order with tags
//     0..4 and correct quotients.
//  4. Random back-to-back traffic with random out_ready and a divider model with
//     variable latency -> every (quo,rmd) matches the golden model, no drops,
//     no duplicates.
//  5. Assert rst during WAIT with 2 entries queued -> outputs return to their
//     reset values; no result is emitted after rst.
//  6. Inject div_done in IDLE -> err=1 and stays 1; out_valid is not asserted.

Source files
------------

// File: rtl/div_stream_ctrl.sv
// div_stream_ctrl: request FIFO plus issue/collect controller wrapped around a
// sequential radix-2 divider. Requests are queued, issued one at a time over the
// divider's start/ready/done handshake, and the results are returned in order on
// a valid/ready port tagged with the request tag. Divide-by-zero never reaches
// the divider: it is answered locally with quo=all-ones, rmd=dividend, dbz=1.
//
// Ports:
//   clk, rst                         clock (rising edge), async active-high reset
//   in_valid/in_ready/in_dvnd/in_dvsr/in_tag   request stream (in_ready = !fifo_full)
//   div_start/div_dvnd/div_dvsr      issue to divider (operands valid with start)
//   div_ready/div_done/div_quo/div_rmd         divider status and result
//   out_valid/out_ready/out_quo/out_rmd/out_tag/out_dbz   result stream
//   err                              sticky: div_done seen while not waiting on it
module div_stream_ctrl #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_dvnd,
  input  logic [W-1:0]     in_dvsr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_start,
  output logic [W-1:0]     div_dvnd,
  output logic [W-1:0]     div_dvsr,
  input  logic             div_ready,
  input  logic             div_done,
  input  logic [W-1:0]     div_quo,
  input  logic [W-1:0]     div_rmd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_quo,
  output logic [W-1:0]     out_rmd,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------- FIFO
  logic [W-1:0]     mem_dvnd [DEPTH];
  logic [W-1:0]     mem_dvsr [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  logic fifo_full, fifo_empty, push, pop;
  logic [W-1:0]     head_dvnd, head_dvsr;
  logic [TAG_W-1:0] head_tag;

  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign in_ready   = ~fifo_full;
  // No push while full, even if the FSM pops in the same cycle.
  assign push       = in_valid & ~fifo_full;

  assign head_dvnd = mem_dvnd[rd_ptr];
  assign head_dvsr = mem_dvsr[rd_ptr];
  assign head_tag  = mem_tag[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_dvnd[i] <= '0;
        mem_dvsr[i] <= '0;
        mem_tag[i]  <= '0;
      end
    end else begin
      if (push) begin
        mem_dvnd[wr_ptr] <= in_dvnd;
        mem_dvsr[wr_ptr] <= in_dvsr;
        mem_tag[wr_ptr]  <= in_tag;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  logic load_dbz, load_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    div_start = 1'b0;
    load_dbz  = 1'b0;
    load_div  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          // Divide-by-zero is answered locally and does not need the divider.
          if (head_dvsr == '0) begin
            pop       = 1'b1;
            load_dbz  = 1'b1;
            state_nxt = HOLD;
          end else if (div_ready) begin
            pop       = 1'b1;
            div_start = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (div_done) begin
          load_div  = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are only meaningful with the start pulse; drive zero otherwise.
  assign div_dvnd  = div_start ? head_dvnd : '0;
  assign div_dvsr  = div_start ? head_dvsr : '0;
  assign out_valid = (state == HOLD);

  // ---------------------------------------------------------------- result regs
  logic [TAG_W-1:0] tag_lat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_lat <= '0;
      out_quo <= '0;
      out_rmd <= '0;
      out_tag <= '0;
      out_dbz <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (div_start) tag_lat <= head_tag;
      if (load_dbz) begin
        out_quo <= {W{1'b1}};
        out_rmd <= head_dvnd;
        out_tag <= head_tag;
        out_dbz <= 1'b1;
      end else if (load_div) begin
        out_quo <= div_quo;
        out_rmd <= div_rmd;
        out_tag <= tag_lat;
        out_dbz <= 1'b0;
      end
      // A done pulse outside WAIT has no request to belong to.
      if (div_done && state != WAIT) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_stream_ctrl.sv
// Testbench for div_stream_ctrl: divider model with variable latency, an
// in-order result scoreboard computed from plain integer division, and
// directed scenarios with literal expectations.
module tb_div_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_dvnd, in_dvsr;
  logic [3:0] in_tag;
  logic       div_start;
  logic [7:0] div_dvnd, div_dvsr;
  logic       div_ready, div_done;
  logic [7:0] div_quo, div_rmd;
  logic       out_valid, out_ready;
  logic [7:0] out_quo, out_rmd;
  logic [3:0] out_tag;
  logic       out_dbz, err;

  always #5 clk = ~clk;

  div_stream_ctrl #(.W(8), .DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dvnd(in_dvnd), .in_dvsr(in_dvsr), .in_tag(in_tag),
    .div_start(div_start), .div_dvnd(div_dvnd), .div_dvsr(div_dvsr),
    .div_ready(div_ready), .div_done(div_done),
    .div_quo(div_quo), .div_rmd(div_rmd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quo(out_quo), .out_rmd(out_rmd), .out_tag(out_tag),
    .out_dbz(out_dbz), .err(err)
  );

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] quo;
    logic [7:0] rmd;
    logic       dbz;
  } res_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic res_t golden(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
    res_t r;
    r.tag = t;
    if (b == 8'd0) begin
      r.quo = 8'hFF;
      r.rmd = a;
      r.dbz = 1'b1;
    end else begin
      r.quo = a / b;
      r.rmd = a % b;
      r.dbz = 1'b0;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- divider model
  int  gen       = 0;
  int  lat_force = 0;
  bit  model_en  = 1'b1;
  int  n_starts  = 0;

  initial begin
    logic [7:0] a, b;
    int g, lat;
    div_ready = 1'b1;
    div_done  = 1'b0;
    div_quo   = '0;
    div_rmd   = '0;
    forever begin
      @(negedge clk);
      if (div_start && model_en && !rst) begin
        a = div_dvnd;
        b = div_dvsr;
        g = gen;
        n_starts++;
        lat = (lat_force > 0) ? lat_force : $urandom_range(0, 5);
        @(posedge clk); #1;
        if (g == gen) div_ready = 1'b0;
        if (lat > 0) begin
          repeat (lat) @(posedge clk);
          #1;
        end
        if (g == gen) begin
          div_done = 1'b1;
          div_quo  = (b == 0) ? 8'hFF : a / b;
          div_rmd  = (b == 0) ? a : a % b;
          @(posedge clk); #1;
          div_done  = 1'b0;
          div_ready = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  res_t expq[$];
  logic [3:0] rx_tags[$];
  int   valid_cycles = 0;

  initial begin
    res_t e, h, got;
    bit   hold_prev;
    hold_prev = 1'b0;
    h = '0;
    forever begin
      @(negedge clk);
      got = '{tag: out_tag, quo: out_quo, rmd: out_rmd, dbz: out_dbz};
      if (rst) begin
        expq.delete();
        hold_prev = 1'b0;
      end else begin
        if (in_valid && in_ready) expq.push_back(golden(in_dvnd, in_dvsr, in_tag));
        if (hold_prev) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_stable", 32'(got), 32'(h));
        end
        if (out_valid) begin
          valid_cycles++;
          if (!out_ready) begin
            h = got;
          end else if (expq.size() == 0) begin
            chk("unexpected_result", 32'(got), 32'hDEAD);
          end else begin
            e = expq.pop_front();
            chk("result", 32'(got), 32'(e));
            rx_tags.push_back(out_tag);
          end
        end
        hold_prev = out_valid && !out_ready;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
    bit ok;
    ok = 1'b0;
    in_dvnd = a; in_dvsr = b; in_tag = t; in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) chk(nm, 32'd0, 32'd1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int s0, base, vc0;
    bit done4;
    rst = 1'b1; in_valid = 1'b0; in_dvnd = '0; in_dvsr = '0; in_tag = '0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outs", {out_valid, div_start, out_dbz, err, out_tag, out_quo, out_rmd}, 32'd0);
    chk("rst_div_ops", {div_dvnd, div_dvsr}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: 100/7 tag 3
    send(8'd100, 8'd7, 4'd3);
    @(negedge clk);
    chk("t1_start", 32'(div_start), 32'd1);
    chk("t1_ops", {div_dvnd, div_dvsr}, {16'd0, 8'd100, 8'd7});
    wait_valid("t1_valid_timeout");
    chk("t1_out", {out_tag, out_quo, out_rmd, out_dbz}, {4'd3, 8'd14, 8'd2, 1'b0});
    repeat (3) @(posedge clk); #1;

    // 2: 55/0 tag 9, answered locally
    s0 = n_starts;
    send(8'd55, 8'd0, 4'd9);
    @(negedge clk);
    chk("t2_no_start", 32'(div_start), 32'd0);
    chk("t2_valid_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t2_valid_c2", 32'(out_valid), 32'd1);
    chk("t2_out", {out_tag, out_quo, out_rmd, out_dbz}, {4'd9, 8'hFF, 8'd55, 1'b1});
    repeat (3) @(negedge clk);
    chk("t2_starts", 32'(n_starts - s0), 32'd0);
    @(posedge clk); #1;

    // 3: backpressure fills 4 queued + 1 in flight
    out_ready = 1'b0;
    base = rx_tags.size();
    for (int i = 0; i < 5; i++) send(8'(200 - 10 * i), 8'(i + 3), 4'(i));
    @(negedge clk);
    chk("t3_full", 32'(in_ready), 32'd0);
    repeat (10) @(negedge clk);
    chk("t3_still_full", 32'(in_ready), 32'd0);
    chk("t3_head", {out_valid, out_tag, out_quo}, {19'd0, 1'b1, 4'd0, 8'd66});
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 300 && rx_tags.size() < base + 5; i++) @(negedge clk);
    chk("t3_count", 32'(rx_tags.size() - base), 32'd5);
    for (int i = 0; i < 5; i++)
      if (base + i < rx_tags.size()) chk("t3_order", 32'(rx_tags[base + i]), 32'(i));
    @(posedge clk); #1;

    // 4: random traffic with random backpressure and divider latency
    base = rx_tags.size();
    done4 = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send(8'($urandom_range(0, 255)), (i % 7 == 0) ? 8'd0 : 8'($urandom_range(0, 255)), 4'(i));
        end
        done4 = 1'b1;
      end
      begin
        while (!done4) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 500 && (expq.size() != 0 || out_valid); i++) @(negedge clk);
    chk("t4_drained", 32'(expq.size()), 32'd0);
    chk("t4_count", 32'(rx_tags.size() - base), 32'd40);
    @(posedge clk); #1;

    // 5: reset during WAIT with 2 queued
    lat_force = 20;
    send(8'd90, 8'd9, 4'd1);
    send(8'd80, 8'd8, 4'd2);
    send(8'd70, 8'd7, 4'd3);
    @(negedge clk);
    chk("t5_waiting", {out_valid, div_start}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; gen++; div_ready = 1'b1; div_done = 1'b0;
    @(negedge clk);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t5_rst_outs", {out_valid, div_start, out_dbz, err, out_tag, out_quo, out_rmd}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lat_force = 0;
    vc0 = valid_cycles;
    repeat (30) @(negedge clk);
    chk("t5_no_result", 32'(valid_cycles - vc0), 32'd0);
    chk("t5_err_clear", 32'(err), 32'd0);
    @(posedge clk); #1;

    // 6: stray done in IDLE
    model_en = 1'b0;
    div_done = 1'b1; div_quo = 8'd5; div_rmd = 8'd6;
    @(posedge clk); #1 div_done = 1'b0;
    @(negedge clk);
    chk("t6_err", {err, out_valid}, {30'd0, 1'b1, 1'b0});
    repeat (5) @(negedge clk);
    chk("t6_err_sticky", {err, out_valid}, {30'd0, 1'b1, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
